// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the frame-DRAM arbiter: bus widths, frame size, lock states.
package dram_arb_pkg;

  localparam int A_WIDTH_DEF = 19;
  localparam int D_WIDTH_DEF = 8;
  localparam int IMG_PIXELS  = 307200;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/dram_arb_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant from a request vector, searching from
// i_ptr, or restricted to i_owner while a burst lock is in force.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_lock,
  input  logic [PW-1:0]   i_owner,
  output logic [NREQ-1:0] o_grant
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (i_lock) begin
      o_grant[i_owner] = i_req[i_owner];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        w_idx = PW'((int'(i_ptr) + k) % NREQ);
        if (!w_found && i_req[w_idx]) begin
          o_grant[w_idx] = 1'b1;
          w_found        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Frame-DRAM arbiter: independent round-robin read and write ports with optional burst lock.
// Define DRAM_ARB_FWD_EN to return write data on a same-cycle read/write address collision.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int A_WIDTH   = A_WIDTH_DEF,
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*A_WIDTH-1:0] req_addr,
  input  logic [NREQ*D_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [D_WIDTH-1:0]      rsp_data,
  output logic                    dram_ren,
  output logic [A_WIDTH-1:0]      dram_raddr,
  output logic                    dram_wen,
  output logic [A_WIDTH-1:0]      dram_waddr,
  output logic [D_WIDTH-1:0]      dram_wdata,
  input  logic [D_WIDTH-1:0]      dram_rdata,
  output logic                    dbg_rd_locked,
  output logic                    dbg_wr_locked
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  // Handshake: a beat from requester i is accepted in any cycle where req_valid[i] &
  // req_ready[i]; ready is combinational and never asserted during reset.

  // Port index 0 = read, 1 = write.
  lock_state_t     r_state [2];
  logic [PW-1:0]   r_ptr   [2];
  logic [PW-1:0]   r_owner [2];
  logic [CW-1:0]   r_cnt   [2];
  logic [NREQ-1:0] w_pool  [2];
  logic [NREQ-1:0] w_grant [2];
  logic [PW-1:0]   w_gidx  [2];
  logic            w_any   [2];
  logic            w_lock_eff [2];

  logic [A_WIDTH-1:0] w_raddr, w_waddr;
  logic [D_WIDTH-1:0] w_wdata;

  logic               r_ren, r_wen;
  logic [A_WIDTH-1:0] r_raddr, r_waddr;
  logic [D_WIDTH-1:0] r_wdata;
  logic [NREQ-1:0]    r_rd_pend, r_rsp_valid;

  assign w_pool[0] = rst ? '0 : (req_valid & ~req_we);
  assign w_pool[1] = rst ? '0 : (req_valid & req_we);

  // A lock only binds while its owner still presents a beat on that port.
  assign w_lock_eff[0] = (r_state[0] == LOCKED) && w_pool[0][r_owner[0]];
  assign w_lock_eff[1] = (r_state[1] == LOCKED) && w_pool[1][r_owner[1]];

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .i_req   (w_pool[0]),
    .i_ptr   (r_ptr[0]),
    .i_lock  (w_lock_eff[0]),
    .i_owner (r_owner[0]),
    .o_grant (w_grant[0])
  );

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .i_req   (w_pool[1]),
    .i_ptr   (r_ptr[1]),
    .i_lock  (w_lock_eff[1]),
    .i_owner (r_owner[1]),
    .o_grant (w_grant[1])
  );

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_gidx[p] = '0;
      w_any[p]  = |w_grant[p];
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant[p][i]) w_gidx[p] = PW'(i);
      end
    end
  end

  assign w_raddr   = req_addr[w_gidx[0]*A_WIDTH +: A_WIDTH];
  assign w_waddr   = req_addr[w_gidx[1]*A_WIDTH +: A_WIDTH];
  assign w_wdata   = req_wdata[w_gidx[1]*D_WIDTH +: D_WIDTH];
  assign req_ready = w_grant[0] | w_grant[1];

  // Lock FSM and round-robin pointer, one copy per port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= IDLE;
        r_ptr[p]   <= '0;
        r_owner[p] <= '0;
        r_cnt[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_lock_eff[p]) begin
          r_ptr[p] <= PW'((int'(r_owner[p]) + 1) % NREQ);
          if (!req_lock[r_owner[p]] || (r_cnt[p] == CW'(MAX_BURST - 1))) begin
            r_state[p] <= IDLE;
            r_cnt[p]   <= '0;
          end else begin
            r_cnt[p] <= r_cnt[p] + 1'b1;
          end
        end else begin
          r_state[p] <= IDLE;
          r_cnt[p]   <= '0;
          if (w_any[p]) begin
            r_ptr[p] <= PW'((int'(w_gidx[p]) + 1) % NREQ);
            if (req_lock[w_gidx[p]] && (MAX_BURST > 1)) begin
              r_state[p] <= LOCKED;
              r_owner[p] <= w_gidx[p];
              r_cnt[p]   <= CW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_rd_pend   <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_ren       <= w_any[0];
      r_wen       <= w_any[1];
      r_rd_pend   <= w_grant[0];
      r_rsp_valid <= r_rd_pend;
      if (w_any[0]) r_raddr <= w_raddr;
      if (w_any[1]) begin
        r_waddr <= w_waddr;
        r_wdata <= w_wdata;
      end
    end
  end

`ifdef DRAM_ARB_FWD_EN
  logic               r_hit, r_fwd_sel;
  logic [D_WIDTH-1:0] r_fwd_data;

  // Collision flag travels alongside the read so it lines up with dram_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit      <= 1'b0;
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_hit      <= w_any[0] && w_any[1] && (w_raddr == w_waddr);
      r_fwd_sel  <= r_hit;
      r_fwd_data <= r_wdata;
    end
  end

  assign rsp_data = (|r_rsp_valid) ? (r_fwd_sel ? r_fwd_data : dram_rdata) : '0;
`else
  assign rsp_data = (|r_rsp_valid) ? dram_rdata : '0;
`endif

  assign rsp_valid     = r_rsp_valid;
  assign dram_ren      = r_ren;
  assign dram_raddr    = r_raddr;
  assign dram_wen      = r_wen;
  assign dram_waddr    = r_waddr;
  assign dram_wdata    = r_wdata;
  assign dbg_rd_locked = (r_state[0] == LOCKED);
  assign dbg_wr_locked = (r_state[1] == LOCKED);

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural 1-cycle-latency DRAM; honours DRAM_ARB_FWD_EN.
module tb_dram_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 19;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_we    = '0;
  logic [NREQ-1:0]    req_lock  = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               dram_ren, dram_wen;
  logic [AW-1:0]      dram_raddr, dram_waddr;
  logic [DW-1:0]      dram_wdata;
  logic [DW-1:0]      dram_rdata;
  logic               dbg_rd_locked, dbg_wr_locked;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  dram_arbiter #(.NREQ(NREQ), .A_WIDTH(AW), .D_WIDTH(DW), .MAX_BURST(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_lock      (req_lock),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .dram_ren      (dram_ren),
    .dram_raddr    (dram_raddr),
    .dram_wen      (dram_wen),
    .dram_waddr    (dram_waddr),
    .dram_wdata    (dram_wdata),
    .dram_rdata    (dram_rdata),
    .dbg_rd_locked (dbg_rd_locked),
    .dbg_wr_locked (dbg_wr_locked)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // DRAM model: read-before-write, preloaded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      mem['h00010] <= 8'h10;
      mem['h00020] <= 8'h20;
      mem['h00000] <= 8'h5C;
      mem['h00100] <= 8'h11;
      dram_rdata   <= '0;
    end else begin
      if (dram_ren) dram_rdata <= mem[dram_raddr];
      if (dram_wen) mem[dram_waddr] <= dram_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic we, input logic lk,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_we[i]           = we;
    req_lock[i]         = lk;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_lock  = '0;
  endtask

  logic [1:0] exp_rdy, exp_rsp;
  logic [7:0] exp_data;

  initial begin
    // 1: reset held two cycles with both requesters valid
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 19'h00010, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 19'h00020, 8'h00);
    @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_ren", 32'(dram_ren), 32'h0);
    check("rst_wen", 32'(dram_wen), 32'h0);
    check("rst_rd_locked", 32'(dbg_rd_locked), 32'h0);
    rst = 1'b0;

    // 2: alternating reads, responses two cycles later
    for (int k = 0; k < 8; k++) begin
      if (k == 6) idle_all();
      #1;
      exp_rdy = (k < 6) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00;
      exp_rsp = (k >= 2) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(exp_rdy));
      check($sformatf("rr_rsp_valid_%0d", k), 32'(rsp_valid), 32'(exp_rsp));
      if (k >= 2) begin
        exp_data = (k % 2) ? 8'h20 : 8'h10;
        check($sformatf("rr_rsp_data_%0d", k), 32'(rsp_data), 32'(exp_data));
      end
      @(negedge clk);
    end

    // 3: simultaneous write (req0) and read (req1)
    drive(0, 1'b1, 1'b1, 1'b0, 19'h7FFFF, 8'h05);
    drive(1, 1'b1, 1'b0, 1'b0, 19'h00000, 8'h00);
    #1;
    check("rw_ready", 32'(req_ready), 32'h3);
    @(negedge clk);
    idle_all();
    #1;
    check("rw_ren", 32'(dram_ren), 32'h1);
    check("rw_wen", 32'(dram_wen), 32'h1);
    check("rw_raddr", 32'(dram_raddr), 32'h00000);
    check("rw_waddr", 32'(dram_waddr), 32'h7FFFF);
    check("rw_wdata", 32'(dram_wdata), 32'h05);
    @(negedge clk);
    #1;
    check("rw_rsp_valid", 32'(rsp_valid), 32'h2);
    check("rw_rsp_data", 32'(rsp_data), 32'h5C);
    check("rw_ren_pulse", 32'(dram_ren), 32'h0);
    check("rw_wen_pulse", 32'(dram_wen), 32'h0);
    check("rw_waddr_hold", 32'(dram_waddr), 32'h7FFFF);
    @(negedge clk);

    // 4: req0 locked burst capped at 16 beats, then req1, then req0 again
    drive(0, 1'b1, 1'b0, 1'b1, 19'h00010, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 19'h00020, 8'h00);
    for (int k = 0; k < 18; k++) begin
      #1;
      exp_rdy = (k == 16) ? 2'b10 : 2'b01;
      check($sformatf("lock_ready_%0d", k), 32'(req_ready), 32'(exp_rdy));
      check($sformatf("lock_state_%0d", k), 32'(dbg_rd_locked),
            32'((k >= 1) && (k <= 15)));
      @(negedge clk);
    end
    idle_all();
    repeat (3) @(negedge clk);

    // 5: same-cycle write and read to 0x00100
    drive(0, 1'b1, 1'b1, 1'b0, 19'h00100, 8'hAA);
    drive(1, 1'b1, 1'b0, 1'b0, 19'h00100, 8'h00);
    #1;
    check("coll_ready", 32'(req_ready), 32'h3);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    #1;
`ifdef DRAM_ARB_FWD_EN
    exp_data = 8'hAA;
`else
    exp_data = 8'h11;
`endif
    check("coll_rsp_valid", 32'(rsp_valid), 32'h2);
    check("coll_rsp_data", 32'(rsp_data), 32'(exp_data));
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b0, 19'h00100, 8'h00);
    #1;
    check("reread_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    #1;
    check("reread_rsp_valid", 32'(rsp_valid), 32'h2);
    check("reread_rsp_data", 32'(rsp_data), 32'hAA);
    @(negedge clk);

    // 6: read granted, reset in the following cycle drops the response
    drive(0, 1'b1, 1'b0, 1'b0, 19'h00020, 8'h00);
    #1;
    check("drop_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("drop_rsp_valid_0", 32'(rsp_valid), 32'h0);
    check("drop_ren", 32'(dram_ren), 32'h0);
    @(negedge clk);
    #1;
    check("drop_rsp_valid_1", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 19'h00010, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 19'h00020, 8'h00);
    #1;
    check("ptr_rd_reset", 32'(req_ready), 32'h1);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 19'h00200, 8'h01);
    drive(1, 1'b1, 1'b1, 1'b0, 19'h00201, 8'h02);
    #1;
    check("ptr_wr_reset", 32'(req_ready), 32'h1);
    @(negedge clk);
    idle_all();
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
